ula_sequencer: RTL and testbench
================================

Name: ula_sequencer

Overview:
Initiator for the combinational ULA. It accepts operation commands over a valid/ready handshake and drives entrada_01, entrada_02 and ULA_control on the ULA. After a fixed settle time it samples ULA_result and Zero and returns them on a valid/ready response channel. It also supports accumulator chaining, where the previous result replaces operand A, and sits between the datapath control and the ULA instance.

Parameters:
WIDTH, 32, operand/result width (matches ULA)
SETTLE_CYCLES, 1, clocks operands are held on ULA before result is sampled (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_op  in  3  ULA_control code
cmd_chain  in  1  1 = use last result as operand A, ignore cmd_a
ula_entrada_01  out  WIDTH  to ULA entrada_01
ula_entrada_02  out  WIDTH  to ULA entrada_02
ula_control  out  3  to ULA ULA_control
ula_result  in  WIDTH  from ULA ULA_result
ula_zero  in  1  from ULA Zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  captured ULA_result
rsp_zero  out  1  captured Zero
op_count  out  CNT_W  completed (handed-off) responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0), all outputs 0:
  - state=IDLE, cmd_ready=0 during reset, rsp_valid=0, rsp_result=0, rsp_zero=0.
  - ula_entrada_01/02=0, ula_control=3'b000, op_count=0, last-result register=0.
- Reset asserted mid-operation aborts the in-flight command. No response is produced for it.
- ULA codes are passed through unchanged; the shared package names them:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
  - 011 and 100 are reserved but still forwarded.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
    - latch operands into the ULA drive registers: A = cmd_chain ? last_result : cmd_a; B = cmd_b; control = cmd_op.
    - load settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: cmd_ready=0, drive registers held stable. When counter==0:
    - capture ula_result/ula_zero into rsp_result/rsp_zero and last_result.
    - assert rsp_valid, go to RESP.
    - otherwise decrement the counter.
  - RESP: cmd_ready=0. rsp_valid, rsp_result and rsp_zero are held stable until rsp_ready. On rsp_valid&&rsp_ready:
    - rsp_valid<=0, op_count+1, go to IDLE.
- Latency: command accepted at edge N gives rsp_valid=1 after edge N+SETTLE_CYCLES+... precisely rsp_valid rises at edge N+SETTLE_CYCLES. With SETTLE_CYCLES=1 that is the next edge.
- Throughput: one command per SETTLE_CYCLES+2 clocks with rsp_ready held high. No overlapping commands.
- ULA drive outputs keep their last values in IDLE. They are not cleared after a response.
- cmd_chain on the first command after reset uses last_result=0.
- rsp_ready asserted while rsp_valid=0 is ignored.
- cmd_valid held high while cmd_ready=0 has no effect. The command is accepted only on return to IDLE.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Package ula_pkg holds:
  - typedef ula_op_t (3-bit enum for AND/OR/ADD/SUB/SLT plus the reserved codes).
  - the state enum.
  - WIDTH default constant.
- One natural sub-module: ula_settle_counter, a loadable down-counter with zero flag. The FSM may also inline it.
- The bench instantiates the real ULA as the responder.

Test Plan:
- Reset: hold rst_n=0 with cmd_valid=1 → cmd_ready=0, rsp_valid=0, op_count=0, all ULA drives 0. After release, cmd_ready=1.
- Basic ops: A=A5A5A5A5, B=5A5A5A5A.
  - op=000 → rsp_result=00000000, rsp_zero=1.
  - op=001 → FFFFFFFF, zero=0.
  - rsp_valid appears 1 clock after acceptance (SETTLE_CYCLES=1).
- Chain: ADD 0000000F+00000001 → 00000010; then chain SUB with B=00000010 → 00000000, zero=1. op_count=2.
- SLT/backpressure: A=0000000A, B=0000000F, op=111 with rsp_ready=0 for 5 clocks:
  - response stays valid and stable at 00000001, cmd_ready=0 throughout.
  - a second command presented meanwhile is accepted only after the handshake.
- Settle/reset abort: SETTLE_CYCLES=3, SUB 0000000F-0000000F → rsp_valid rises exactly 3 edges after acceptance. Repeat with rst_n pulsed low during SETTLE → no response, op_count unchanged at 0.
- Counter wrap: CNT_W=2, complete 5 commands → op_count reads 1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer: operation codes, FSM states and
// the default datapath width.
package ula_pkg;

  localparam int unsigned ULA_WIDTH = 32;

  // ULA_control codes. 011 and 100 are reserved but still forwarded.
  typedef enum logic [2:0] {
    ULA_AND  = 3'b000,
    ULA_OR   = 3'b001,
    ULA_ADD  = 3'b010,
    ULA_RSV3 = 3'b011,
    ULA_RSV4 = 3'b100,
    ULA_SUB  = 3'b110,
    ULA_SLT  = 3'b111
  } ula_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } seq_state_t;

  // Width of a down-counter that must hold settle-1.
  function automatic int unsigned settle_cnt_w(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/ula_sequencer_if.sv
// Command, response and ULA drive signals for the ULA sequencer.
interface ula_sequencer_if import ula_pkg::*; #(
  parameter int unsigned WIDTH = ULA_WIDTH
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  ula_op_t          cmd_op;
  logic             cmd_chain;

  logic [WIDTH-1:0] ula_entrada_01;
  logic [WIDTH-1:0] ula_entrada_02;
  ula_op_t          ula_control;
  logic [WIDTH-1:0] ula_result;
  logic             ula_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
    output cmd_ready,
    output ula_entrada_01, ula_entrada_02, ula_control,
    input  ula_result, ula_zero,
    output rsp_valid, rsp_result, rsp_zero,
    input  rsp_ready
  );

  // Datapath control side, which also hosts the ULA instance.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
    input  cmd_ready,
    input  ula_entrada_01, ula_entrada_02, ula_control,
    output ula_result, ula_zero,
    input  rsp_valid, rsp_result, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/ula_sequencer_settle_counter.sv
// Loadable down-counter with zero flag; times how long operands sit on the ULA.
module ula_settle_counter #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero
);
  logic [W-1:0] count;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/ula_sequencer.sv
// Initiator for the combinational ULA: accepts a command, holds the operands
// on the ULA for SETTLE_CYCLES clocks, then returns the sampled result.
module ula_sequencer import ula_pkg::*; #(
  parameter int unsigned WIDTH         = ULA_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ula_sequencer_if.slave   bus,
  output logic [CNT_W-1:0] op_count
);
  localparam int unsigned       CW          = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  seq_state_t       state, state_nxt;
  logic             accept, capture, done;
  logic             cnt_load, cnt_dec, cnt_zero;

  logic [WIDTH-1:0] ent1_q, ent2_q, last_result;
  ula_op_t          ctl_q;
  logic             rsp_valid_q, rsp_zero_q;
  logic [WIDTH-1:0] rsp_result_q;

  // Gated with rst_n so no command is accepted while reset is held.
  assign bus.cmd_ready = rst_n && (state == ST_IDLE);

  ula_settle_counter #(.W(CW)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          accept    = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand drive, result capture and completion counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent1_q       <= '0;
      ent2_q       <= '0;
      ctl_q        <= ULA_AND;
      last_result  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        ent1_q <= bus.cmd_chain ? last_result : bus.cmd_a;
        ent2_q <= bus.cmd_b;
        ctl_q  <= bus.cmd_op;
      end
      if (capture) begin
        rsp_result_q <= bus.ula_result;
        rsp_zero_q   <= bus.ula_zero;
        last_result  <= bus.ula_result;
        rsp_valid_q  <= 1'b1;
      end
      if (done) begin
        rsp_valid_q <= 1'b0;
        op_count    <= op_count + 1'b1;
      end
    end
  end

  assign bus.ula_entrada_01 = ent1_q;
  assign bus.ula_entrada_02 = ent2_q;
  assign bus.ula_control    = ctl_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.rsp_zero       = rsp_zero_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer. Three instances cover the default
// configuration (0), SETTLE_CYCLES=3 (1) and CNT_W=2 (2); each is answered by
// a combinational ULA model.
module tb_ula_sequencer;
  import ula_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn[3], cv[3], ch[3], rr[3];
  logic [31:0] ca[3], cb[3];
  logic [2:0]  co[3];
  logic        rdy[3], rv[3], rz[3];
  logic [31:0] rres[3], e1[3], e2[3];
  logic [2:0]  ctl[3];
  logic [15:0] occ[3];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [32:0] ula_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  ula_sequencer_if #(.WIDTH(32)) bus[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S  = (g == 1) ? 3 : 1;
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] oc;

    assign bus[g].cmd_valid = cv[g];
    assign bus[g].cmd_a     = ca[g];
    assign bus[g].cmd_b     = cb[g];
    assign bus[g].cmd_op    = ula_op_t'(co[g]);
    assign bus[g].cmd_chain = ch[g];
    assign bus[g].rsp_ready = rr[g];
    assign {bus[g].ula_zero, bus[g].ula_result} =
      ula_model(bus[g].ula_entrada_01, bus[g].ula_entrada_02, bus[g].ula_control);

    assign rdy[g]  = bus[g].cmd_ready;
    assign rv[g]   = bus[g].rsp_valid;
    assign rres[g] = bus[g].rsp_result;
    assign rz[g]   = bus[g].rsp_zero;
    assign e1[g]   = bus[g].ula_entrada_01;
    assign e2[g]   = bus[g].ula_entrada_02;
    assign ctl[g]  = bus[g].ula_control;
    assign occ[g]  = 16'(oc);

    ula_sequencer #(.WIDTH(32), .SETTLE_CYCLES(S), .CNT_W(CW)) u_dut (
      .clk      (clk),
      .rst_n    (rn[g]),
      .bus      (bus[g]),
      .op_count (oc)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, let one edge accept it.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic chain);
    int w = 0;
    ca[k] = a; cb[k] = b; co[k] = op; ch[k] = chain; cv[k] = 1'b1;
    while (!rdy[k] && w < 20) begin tick(); w++; end
    check("issue_ready", 32'(rdy[k]), 32'd1);
    tick();
    cv[k] = 1'b0; ch[k] = 1'b0;
  endtask

  // Count edges after acceptance until rsp_valid, then check the payload.
  task automatic wait_rsp(input int k, input logic [31:0] res, input logic z, input int lat);
    int n = 0;
    while (!rv[k] && n < 20) begin tick(); n++; end
    check("rsp_latency", 32'(n), 32'(lat));
    check("rsp_result", rres[k], res);
    check("rsp_zero", 32'(rz[k]), 32'(z));
  endtask

  task automatic ack(input int k);
    rr[k] = 1'b1;
    tick();
    rr[k] = 1'b0;
    check("rsp_valid_drop", 32'(rv[k]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rn[i] = 1'b0; cv[i] = 1'b1; ch[i] = 1'b0; rr[i] = 1'b0;
      ca[i] = 32'hA5A5A5A5; cb[i] = 32'h5A5A5A5A; co[i] = 3'b010;
    end

    // Reset held with cmd_valid high.
    tick(3);
    check("rst_cmd_ready", 32'(rdy[0]), 32'd0);
    check("rst_rsp_valid", 32'(rv[0]), 32'd0);
    check("rst_op_count", 32'(occ[0]), 32'd0);
    check("rst_ent1", e1[0], 32'd0);
    check("rst_ent2", e2[0], 32'd0);
    check("rst_ctl", 32'(ctl[0]), 32'd0);
    check("rst_rsp_result", rres[0], 32'd0);
    for (int i = 0; i < 3; i++) begin cv[i] = 1'b0; rn[i] = 1'b1; end
    tick();
    check("post_rst_ready0", 32'(rdy[0]), 32'd1);
    check("post_rst_ready1", 32'(rdy[1]), 32'd1);

    // Basic AND / OR.
    issue(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b000, 1'b0);
    wait_rsp(0, 32'h00000000, 1'b1, 1);
    ack(0);
    issue(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, 1'b0);
    wait_rsp(0, 32'hFFFFFFFF, 1'b0, 1);
    ack(0);
    check("count_after_basic", 32'(occ[0]), 32'd2);
    check("ent1_held_idle", e1[0], 32'hA5A5A5A5);
    check("ctl_held_idle", 32'(ctl[0]), 32'd1);

    // Chain: 0F+01=10, then (last=10)-10=0.
    issue(0, 32'h0000000F, 32'h00000001, 3'b010, 1'b0);
    wait_rsp(0, 32'h00000010, 1'b0, 1);
    ack(0);
    issue(0, 32'hDEADBEEF, 32'h00000010, 3'b110, 1'b1);
    wait_rsp(0, 32'h00000000, 1'b1, 1);
    check("chain_ent1", e1[0], 32'h00000010);
    ack(0);
    check("count_after_chain", 32'(occ[0]), 32'd4);

    // SLT under backpressure with a second command waiting.
    issue(0, 32'h0000000A, 32'h0000000F, 3'b111, 1'b0);
    wait_rsp(0, 32'h00000001, 1'b0, 1);
    ca[0] = 32'h00000003; cb[0] = 32'h0000000C; co[0] = 3'b001; cv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rv[0]), 32'd1);
      check("bp_result", rres[0], 32'h00000001);
      check("bp_zero", 32'(rz[0]), 32'd0);
      check("bp_cmd_ready", 32'(rdy[0]), 32'd0);
      tick();
    end
    check("bp_ent1_stable", e1[0], 32'h0000000A);
    check("bp_ctl_stable", 32'(ctl[0]), 32'd7);
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;
    check("bp_released_valid", 32'(rv[0]), 32'd0);
    check("bp_released_ready", 32'(rdy[0]), 32'd1);
    check("bp_second_not_yet", e1[0], 32'h0000000A);
    tick();
    cv[0] = 1'b0;
    check("second_ctl", 32'(ctl[0]), 32'd1);
    check("second_ent1", e1[0], 32'h00000003);
    wait_rsp(0, 32'h0000000F, 1'b0, 1);
    ack(0);
    check("count_after_bp", 32'(occ[0]), 32'd6);

    // rsp_ready with no response pending is ignored.
    rr[0] = 1'b1;
    tick(2);
    rr[0] = 1'b0;
    check("idle_ready_valid", 32'(rv[0]), 32'd0);
    check("idle_ready_count", 32'(occ[0]), 32'd6);

    // Reserved code forwarded unchanged.
    issue(0, 32'h00000001, 32'h00000002, 3'b011, 1'b0);
    check("rsv_ctl", 32'(ctl[0]), 32'd3);
    wait_rsp(0, 32'h00000000, 1'b1, 1);
    ack(0);

    // SETTLE_CYCLES=3: latency, then abort by reset mid-settle.
    issue(1, 32'h0000000F, 32'h0000000F, 3'b110, 1'b0);
    wait_rsp(1, 32'h00000000, 1'b1, 3);
    ack(1);
    check("s3_count", 32'(occ[1]), 32'd1);
    issue(1, 32'h00000005, 32'h00000003, 3'b010, 1'b0);
    tick();
    rn[1] = 1'b0;
    #2;
    check("abort_valid", 32'(rv[1]), 32'd0);
    check("abort_count", 32'(occ[1]), 32'd0);
    check("abort_ent1", e1[1], 32'd0);
    check("abort_ready", 32'(rdy[1]), 32'd0);
    rn[1] = 1'b1;
    tick();
    check("abort_ready_back", 32'(rdy[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_rsp", 32'(rv[1]), 32'd0);
      tick();
    end
    check("abort_count_final", 32'(occ[1]), 32'd0);
    // Chain right after reset uses last_result = 0.
    issue(1, 32'h0000FFFF, 32'h00000007, 3'b010, 1'b1);
    wait_rsp(1, 32'h00000007, 1'b0, 3);
    ack(1);

    // CNT_W=2 wraps after four completions.
    for (int i = 0; i < 5; i++) begin
      issue(2, 32'(i), 32'd1, 3'b010, 1'b0);
      wait_rsp(2, 32'(i + 1), 1'b0, 1);
      ack(2);
      if (i == 3) check("wrap_at_4", 32'(occ[2]), 32'd0);
    end
    check("wrap_at_5", 32'(occ[2]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
